// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment driver for common-anode displays.
// Scans NUM_DIGITS digits over one segment bus with blanking, dp, zero suppression and frame-aligned updates.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 500
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    lz_en,
  output logic [7:0]              leds,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp_val;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic                    r_disp_lz;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_lz;
  logic                    r_pend_flag;

  logic                    w_slot_end;
  logic                    w_frame_wrap;
  logic                    w_apply;
  logic                    w_lit;
  logic [NUM_DIGITS-1:0]   w_zero_above;
  logic [NUM_DIGITS-1:0]   w_anode;
  logic [7:0]              w_digit_code [NUM_DIGITS];

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign w_slot_end   = (r_cnt == CNT_LAST);
  assign w_frame_wrap = enable & w_slot_end & (r_idx == IDX_LAST);
  // While dark there is no frame to tear, so pending data lands at once.
  assign w_apply      = (~enable | w_frame_wrap) & (r_pend_flag | load);

  generate
    if (BLANK_CYC == 0) begin : g_noblank
      assign w_lit = 1'b1;
    end else begin : g_blank
      assign w_lit = (r_cnt >= CW'(BLANK_CYC));
    end
  endgenerate

  // w_zero_above[i]: every nibble from i up to the top digit is zero.
  always_comb begin
    logic v_run;
    v_run        = 1'b1;
    w_zero_above = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_run           = v_run & (r_disp_val[4*i +: 4] == 4'h0);
      w_zero_above[i] = v_run;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_units
        assign w_digit_code[gi] = {~r_disp_dp[gi], seg_decode(r_disp_val[4*gi +: 4])};
      end else begin : g_upper
        assign w_digit_code[gi] = (r_disp_lz && w_zero_above[gi]) ?
                                  {~r_disp_dp[gi], 7'h7F} :
                                  {~r_disp_dp[gi], seg_decode(r_disp_val[4*gi +: 4])};
      end
      assign w_anode[gi] = ~(w_lit && (r_idx == IW'(gi)));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      leds       <= 8'hFF;
      digit_en   <= '1;
      frame_tick <= 1'b0;
    end else if (!enable) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      leds       <= 8'hFF;
      digit_en   <= '1;
      frame_tick <= 1'b0;
    end else begin
      leds       <= w_digit_code[r_idx];
      digit_en   <= w_anode;
      frame_tick <= w_frame_wrap;
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_disp_val  <= '0;
      r_disp_dp   <= '0;
      r_disp_lz   <= 1'b0;
      r_pend_val  <= '0;
      r_pend_dp   <= '0;
      r_pend_lz   <= 1'b0;
      r_pend_flag <= 1'b0;
    end else begin
      if (load) begin
        r_pend_val <= value;
        r_pend_dp  <= dp;
        r_pend_lz  <= lz_en;
      end
      if (w_apply) begin
        r_disp_val  <= load ? value : r_pend_val;
        r_disp_dp   <= load ? dp    : r_pend_dp;
        r_disp_lz   <= load ? lz_en : r_pend_lz;
        r_pend_flag <= 1'b0;
      end else if (load) begin
        r_pend_flag <= 1'b1;
      end
    end
  end

endmodule
